// File: rtl/wb_slave_mem_bfm_if.sv
// Wishbone B4 bus bundle between a master BFM and the memory-backed slave responder.
interface wb_slave_mem_bfm_if #(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32
);
    logic [WB_ADDR_WIDTH-1:0]   ADR;
    logic [WB_DATA_WIDTH-1:0]   DAT_W;
    logic [WB_DATA_WIDTH-1:0]   DAT_R;
    logic                       CYC;
    logic                       STB;
    logic                       WE;
    logic [WB_DATA_WIDTH/8-1:0] SEL;
    logic [2:0]                 CTI;
    logic [1:0]                 BTE;
    logic                       ACK;
    logic                       ERR;

    modport master (
        output ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE,
        input  DAT_R, ACK, ERR
    );

    modport slave (
        input  ADR, DAT_W, CYC, STB, WE, SEL, CTI, BTE,
        output DAT_R, ACK, ERR
    );
endinterface

// File: rtl/wb_slave_mem_bfm.sv
// Wishbone B4 slave responder backed by a word-addressed memory. Supports programmable
// wait states before the first beat, classic cycles, registered-feedback incrementing
// bursts (linear / wrap4 / wrap8 / wrap16) and ERR for addresses outside the window.
module wb_slave_mem_bfm #(
    parameter int unsigned             WB_ADDR_WIDTH  = 32,
    parameter int unsigned             WB_DATA_WIDTH  = 32,
    parameter int unsigned             MEM_WORDS_LOG2 = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic              clk,
    input  logic              rstn,
    wb_slave_mem_bfm_if.slave wb,
    input  logic [3:0]        wait_states,
    output logic [31:0]       ack_count
);
    localparam int unsigned              NB      = WB_DATA_WIDTH / 8;
    localparam int unsigned              SHIFT   = $clog2(NB);
    localparam int unsigned              DEPTH   = 2 ** MEM_WORDS_LOG2;
    localparam logic [WB_ADDR_WIDTH-1:0] DEPTH_W = WB_ADDR_WIDTH'(DEPTH);
    localparam logic [WB_ADDR_WIDTH-1:0] ONE_W   = WB_ADDR_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StWait, StBeat} state_t;

    state_t                     r_state, w_state_nxt;
    logic [3:0]                 r_wcnt, w_wcnt_nxt;
    // Full-width word offset from BASE_ADDR; upper bits let a linear burst detect
    // running off the end of the window.
    logic [WB_ADDR_WIDTH-1:0]   r_woff, w_woff_nxt;
    logic                       r_inwin, w_inwin_nxt;
    logic                       r_ack, w_ack_nxt;
    logic                       r_err, w_err_nxt;
    logic [WB_DATA_WIDTH-1:0]   r_dat_r, w_dat_r_nxt;
    logic [31:0]                r_ack_count, w_ack_count_nxt;
    logic [WB_DATA_WIDTH-1:0]   r_mem [DEPTH];

    logic [WB_ADDR_WIDTH-1:0]   w_req_woff;
    logic                       w_req_inwin;
    logic [WB_ADDR_WIDTH-1:0]   w_burst_woff;
    logic                       w_burst_inwin;
    logic                       w_fetch;
    logic                       w_fetch_inwin;
    logic [MEM_WORDS_LOG2-1:0]  w_fetch_idx;
    logic                       w_beat;
    logic                       w_wr_en;

    assign w_req_woff  = (wb.ADR - BASE_ADDR) >> SHIFT;
    assign w_req_inwin = (wb.ADR >= BASE_ADDR) && (w_req_woff < DEPTH_W);

    // A beat completes on an edge where our ACK is up and the master still strobes.
    assign w_beat  = (r_state == StBeat) && r_ack && wb.CYC && wb.STB;
    assign w_wr_en = w_beat && wb.WE && rstn;

    // Next burst word: linear increments, wrapN cycles the low log2(N) index bits.
    always_comb begin
        w_burst_woff = r_woff;
        case (wb.BTE)
            2'b00:   w_burst_woff      = r_woff + ONE_W;
            2'b01:   w_burst_woff[1:0] = r_woff[1:0] + 2'd1;
            2'b10:   w_burst_woff[2:0] = r_woff[2:0] + 3'd1;
            default: w_burst_woff[3:0] = r_woff[3:0] + 4'd1;
        endcase
        w_burst_inwin = (w_burst_woff < DEPTH_W);
    end

    // Next-state and registered-output computation for the IDLE/WAIT/BEAT machine.
    always_comb begin
        w_state_nxt     = r_state;
        w_wcnt_nxt      = r_wcnt;
        w_woff_nxt      = r_woff;
        w_inwin_nxt     = r_inwin;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_dat_r_nxt     = r_dat_r;
        w_ack_count_nxt = r_ack_count;
        w_fetch         = 1'b0;
        w_fetch_inwin   = r_inwin;
        w_fetch_idx     = r_woff[MEM_WORDS_LOG2-1:0];

        case (r_state)
            StIdle: begin
                if (wb.CYC && wb.STB) begin
                    w_woff_nxt  = w_req_woff;
                    w_inwin_nxt = w_req_inwin;
                    w_wcnt_nxt  = wait_states;
                    if (wait_states != 4'd0) begin
                        w_state_nxt = StWait;
                    end else begin
                        w_state_nxt   = StBeat;
                        w_fetch       = 1'b1;
                        w_fetch_inwin = w_req_inwin;
                        w_fetch_idx   = w_req_woff[MEM_WORDS_LOG2-1:0];
                    end
                end
            end
            StWait: begin
                if (!wb.CYC) begin
                    w_state_nxt = StIdle;
                end else if (r_wcnt == 4'd1) begin
                    w_wcnt_nxt  = 4'd0;
                    w_state_nxt = StBeat;
                    w_fetch     = 1'b1;
                end else begin
                    w_wcnt_nxt = r_wcnt - 4'd1;
                end
            end
            StBeat: begin
                if (!wb.CYC || r_err) begin
                    // Abort, or an ERR beat that always ends the cycle.
                    w_state_nxt = StIdle;
                end else if (r_ack) begin
                    if (wb.STB) begin
                        w_ack_count_nxt = r_ack_count + 32'd1;
                        if (wb.CTI == 3'b010) begin
                            w_woff_nxt    = w_burst_woff;
                            w_inwin_nxt   = w_burst_inwin;
                            w_fetch       = 1'b1;
                            w_fetch_inwin = w_burst_inwin;
                            w_fetch_idx   = w_burst_woff[MEM_WORDS_LOG2-1:0];
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end
                    // STB low: master wait, ACK drops, address held.
                end else if (wb.STB) begin
                    // Master resumes after a wait; re-present the held beat.
                    w_fetch = 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_fetch) begin
            w_ack_nxt   = w_fetch_inwin;
            w_err_nxt   = !w_fetch_inwin;
            w_dat_r_nxt = w_fetch_inwin ? r_mem[w_fetch_idx] : '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= StIdle;
            r_wcnt      <= '0;
            r_woff      <= '0;
            r_inwin     <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_dat_r     <= '0;
            r_ack_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_woff      <= w_woff_nxt;
            r_inwin     <= w_inwin_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_dat_r     <= w_dat_r_nxt;
            r_ack_count <= w_ack_count_nxt;
        end
    end

    // Byte-lane write of the acked beat; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (wb.SEL[i]) begin
                    r_mem[r_woff[MEM_WORDS_LOG2-1:0]][8*i +: 8] <= wb.DAT_W[8*i +: 8];
                end
            end
        end
    end

    assign wb.ACK    = r_ack;
    assign wb.ERR    = r_err;
    assign wb.DAT_R  = r_dat_r;
    assign ack_count = r_ack_count;
endmodule

// File: tb/tb_wb_slave_mem_bfm.sv
// Directed bench for wb_slave_mem_bfm: classic cycles with wait states, byte lanes,
// wrap4 and linear bursts with a master wait, out-of-window ERR and reset mid-cycle.
module tb_wb_slave_mem_bfm;
    logic        clk;
    logic        rstn;
    logic [3:0]  wait_states;
    logic [31:0] ack_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] x_rdat;
    int          x_lat;
    logic        x_ack;
    logic        x_err;
    logic [31:0] burst_rd [16];
    int          burst_wait [16];
    logic        burst_gap_ack;
    logic        saw;

    wb_slave_mem_bfm_if #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32)) bus ();

    wb_slave_mem_bfm #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .MEM_WORDS_LOG2(10),
        .BASE_ADDR     (32'h0)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wb         (bus),
        .wait_states(wait_states),
        .ack_count  (ack_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One classic cycle; lat = edges from the request-sampling edge to the ACK/ERR edge.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int lat,
                           output logic got_ack, output logic got_err);
        logic done;
        done    = 1'b0;
        lat     = 0;
        rdat    = '0;
        got_ack = 1'b0;
        got_err = 1'b0;
        bus.ADR = adr; bus.DAT_W = wdat; bus.SEL = sel; bus.WE = we;
        bus.CTI = 3'b000; bus.BTE = 2'b00; bus.CYC = 1'b1; bus.STB = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.ACK || bus.ERR) begin
                got_ack = bus.ACK;
                got_err = bus.ERR;
                rdat    = bus.DAT_R;
                done    = 1'b1;
            end
            @(posedge clk);
            lat++;
        end
        #1;
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
        if (!done) begin
            check("xfer_timeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check("ack_pulse", {30'd0, bus.ACK, bus.ERR}, 32'd0);
        end
    endtask

    // Registered-feedback burst; optionally drops STB for gap_len cycles before beat gap_after.
    task automatic wb_burst(input logic we, input logic [31:0] adr, input logic [1:0] bte,
                            input int nbeats, input int gap_after, input int gap_len,
                            input logic [31:0] wbase);
        logic got;
        int   w;
        bus.ADR = adr; bus.WE = we; bus.BTE = bte; bus.SEL = 4'hF; bus.DAT_W = wbase;
        bus.CTI = (nbeats == 1) ? 3'b111 : 3'b010;
        bus.CYC = 1'b1; bus.STB = 1'b1;
        @(posedge clk);
        for (int b = 0; b < nbeats; b++) begin
            got = 1'b0;
            w   = 0;
            for (int i = 0; i < 40 && !got; i++) begin
                @(negedge clk);
                if (bus.ACK) begin
                    got         = 1'b1;
                    burst_rd[b] = bus.DAT_R;
                end else begin
                    w++;
                end
                @(posedge clk);
            end
            if (!got) begin
                check("burst_timeout", 32'd0, 32'd1);
                break;
            end
            burst_wait[b] = w;
            #1;
            bus.DAT_W = wbase + 32'(b + 1);
            bus.ADR   = bus.ADR + 32'd4;
            bus.CTI   = (b + 1 == nbeats - 1) ? 3'b111 : 3'b010;
            if (b + 1 == gap_after && gap_len > 0) begin
                bus.STB = 1'b0;
                repeat (gap_len) begin
                    @(negedge clk);
                    burst_gap_ack = bus.ACK;
                    @(posedge clk);
                end
                #1;
                bus.STB = 1'b1;
            end
        end
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0; bus.CTI = 3'b000;
        @(negedge clk);
        check("burst_end_ack", 32'(bus.ACK), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        wait_states = 4'd0;
        bus.ADR = '0; bus.DAT_W = '0; bus.SEL = '0; bus.WE = 1'b0;
        bus.CTI = 3'b000; bus.BTE = 2'b00; bus.CYC = 1'b0; bus.STB = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(bus.ACK), 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        check("rst_dat_r", bus.DAT_R, 32'd0);
        check("rst_ack_count", ack_count, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Zero wait states: write then read back.
        wb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t1_wr_lat", 32'(x_lat), 32'd1);
        check("t1_wr_ack", 32'(x_ack), 32'd1);
        wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t1_rd_lat", 32'(x_lat), 32'd1);
        check("t1_rd_dat", x_rdat, 32'hDEADBEEF);
        check("t1_ack_count", ack_count, 32'd2);

        // Three wait states, then a single-lane write.
        wait_states = 4'd3;
        wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t2_rd_lat", 32'(x_lat), 32'd4);
        check("t2_rd_dat", x_rdat, 32'hDEADBEEF);
        wb_xfer(1'b1, 32'h10, 32'h0000AA00, 4'b0010, x_rdat, x_lat, x_ack, x_err);
        check("t2_wr_lat", 32'(x_lat), 32'd4);
        wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t2_lane_dat", x_rdat, 32'hDEADAAEF);
        check("t2_ack_count", ack_count, 32'd5);

        // Preload words 0..15 with their index, then a wrap4 read burst from 0x08.
        wait_states = 4'd0;
        for (int i = 0; i < 16; i++) begin
            wb_xfer(1'b1, 32'(i * 4), 32'(i), 4'hF, x_rdat, x_lat, x_ack, x_err);
        end
        check("t3_preload_count", ack_count, 32'd21);
        wb_burst(1'b0, 32'h08, 2'b01, 4, -1, 0, 32'h0);
        check("t3_b0_dat", burst_rd[0], 32'd2);
        check("t3_b1_dat", burst_rd[1], 32'd3);
        check("t3_b2_dat", burst_rd[2], 32'd0);
        check("t3_b3_dat", burst_rd[3], 32'd1);
        for (int b = 0; b < 4; b++) begin
            check("t3_b_wait", 32'(burst_wait[b]), 32'd0);
        end
        check("t3_ack_count", ack_count, 32'd25);

        // Linear 8-beat write burst from 0x100 with a 2-cycle master wait after beat 3.
        wb_burst(1'b1, 32'h100, 2'b00, 8, 3, 2, 32'hA0);
        check("t4_gap_ack", 32'(burst_gap_ack), 32'd0);
        for (int b = 0; b < 8; b++) begin
            check("t4_b_wait", 32'(burst_wait[b]), (b == 3) ? 32'd1 : 32'd0);
        end
        check("t4_ack_count", ack_count, 32'd33);
        for (int i = 0; i < 8; i++) begin
            wb_xfer(1'b0, 32'h100 + 32'(i * 4), 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
            check("t4_readback", x_rdat, 32'hA0 + 32'(i));
        end

        // Out-of-window read and write: ERR, no ACK, no count, memory untouched.
        wb_xfer(1'b0, 32'h1000, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t5_err", 32'(x_err), 32'd1);
        check("t5_ack", 32'(x_ack), 32'd0);
        check("t5_dat_r", x_rdat, 32'd0);
        check("t5_lat", 32'(x_lat), 32'd1);
        wb_xfer(1'b1, 32'h1010, 32'h12345678, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t5_wr_err", 32'(x_err), 32'd1);
        check("t5_ack_count", ack_count, 32'd41);
        wb_xfer(1'b0, 32'h10, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t5_mem_kept", x_rdat, 32'd4);

        // Reset while a write sits in WAIT with five wait states.
        wait_states = 4'd5;
        bus.ADR = 32'h20; bus.DAT_W = 32'h55555555; bus.SEL = 4'hF; bus.WE = 1'b1;
        bus.CTI = 3'b000; bus.CYC = 1'b1; bus.STB = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            saw = saw | bus.ACK | bus.ERR;
        end
        rstn = 1'b0;
        bus.CYC = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_no_ack_in_wait", 32'(saw), 32'd0);
        check("t6_rst_ack", 32'(bus.ACK), 32'd0);
        check("t6_rst_err", 32'(bus.ERR), 32'd0);
        check("t6_rst_count", ack_count, 32'd0);
        check("t6_rst_dat_r", bus.DAT_R, 32'd0);
        rstn = 1'b1;
        wait_states = 4'd0;
        @(negedge clk);
        wb_xfer(1'b0, 32'h20, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t6_word_kept", x_rdat, 32'd8);
        wb_xfer(1'b1, 32'h20, 32'h55555555, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t6_wr_ack", 32'(x_ack), 32'd1);
        wb_xfer(1'b0, 32'h20, 32'h0, 4'hF, x_rdat, x_lat, x_ack, x_err);
        check("t6_wr_dat", x_rdat, 32'h55555555);
        check("t6_ack_count", ack_count, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
